// File: rtl/alu_pkg.sv
// Shared opcode encodings and the registered output bundle for the MCU51 ALU.
package alu_pkg;

  localparam logic [3:0] ALU_INC  = 4'b0000;
  localparam logic [3:0] ALU_DEC  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_ADDC = 4'b0011;
  localparam logic [3:0] ALU_ORL  = 4'b0100;
  localparam logic [3:0] ALU_ANL  = 4'b0101;
  localparam logic [3:0] ALU_XRL  = 4'b0110;
  localparam logic [3:0] ALU_CPL  = 4'b0111;
  localparam logic [3:0] ALU_DA   = 4'b1000;
  localparam logic [3:0] ALU_SUBB = 4'b1001;
  localparam logic [3:0] ALU_RR   = 4'b1100;
  localparam logic [3:0] ALU_RRC  = 4'b1101;
  localparam logic [3:0] ALU_RL   = 4'b1110;
  localparam logic [3:0] ALU_RLC  = 4'b1111;

  typedef struct packed {
    logic [7:0] result;
    logic       carry;
    logic       aux_carry;
    logic       overflow;
  } alu_out_t;

endpackage

// File: rtl/alu_addsub.sv
// 8-bit adder/subtractor in two nibble stages; flags are carries for add and borrows for subtract.
module alu_addsub (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  input  logic       sub_i,
  output logic [7:0] sum_o,
  output logic       c3_o,
  output logic       c6_o,
  output logic       c7_o
);

  logic [7:0] b_x;
  logic       cin_x;
  logic [4:0] lo_sum;
  logic [3:0] mid_sum;
  logic [1:0] top_sum;

  // Subtract as a + ~b + ~borrow_in; borrows are the inverted carries.
  assign b_x   = sub_i ? ~b_i : b_i;
  assign cin_x = sub_i ? ~cin_i : cin_i;

  assign lo_sum = {1'b0, a_i[3:0]} + {1'b0, b_x[3:0]} + {4'b0000, cin_x};

  // High nibble is split at bit 6 so the carry into bit 7 is visible for OV.
  assign mid_sum = {1'b0, a_i[6:4]} + {1'b0, b_x[6:4]} + {3'b000, lo_sum[4]};
  assign top_sum = {1'b0, a_i[7]} + {1'b0, b_x[7]} + {1'b0, mid_sum[3]};

  assign sum_o = {top_sum[0], mid_sum[2:0], lo_sum[3:0]};
  assign c3_o  = lo_sum[4] ^ sub_i;
  assign c6_o  = mid_sum[3] ^ sub_i;
  assign c7_o  = top_sum[1] ^ sub_i;

endmodule

// File: rtl/alu.sv
// MCU51 ALU: opcode mux, decimal-adjust correction and registered result/PSW flags.
module alu
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ALUCode,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cy,
  input  logic       AC,
  output logic [7:0] Result,
  output logic       Carry,
  output logic       AssistantCarry,
  output logic       OVerflow
);

  alu_out_t out_d;
  alu_out_t out_q;

  logic [7:0] as_b;
  logic       as_cin;
  logic       as_sub;
  logic [7:0] as_sum;
  logic       as_c3;
  logic       as_c6;
  logic       as_c7;

  logic       da_lo_adj;
  logic       da_hi_adj;
  logic [8:0] da_step1;
  logic [8:0] da_step2;

  // INC/DEC reuse the adder as A+0+1 and A-0-1.
  always_comb begin
    as_b   = B;
    as_cin = 1'b0;
    as_sub = 1'b0;
    case (ALUCode)
      ALU_INC:  begin as_b = 8'h00; as_cin = 1'b1; end
      ALU_DEC:  begin as_b = 8'h00; as_cin = 1'b1; as_sub = 1'b1; end
      ALU_ADDC: as_cin = Cy;
      ALU_SUBB: begin as_cin = Cy; as_sub = 1'b1; end
      default:  ;
    endcase
  end

  alu_addsub u_addsub (
    .a_i   (A),
    .b_i   (as_b),
    .cin_i (as_cin),
    .sub_i (as_sub),
    .sum_o (as_sum),
    .c3_o  (as_c3),
    .c6_o  (as_c6),
    .c7_o  (as_c7)
  );

  // Decimal adjust: low-nibble fix first, then the high nibble sees its carry.
  assign da_lo_adj = (A[3:0] > 4'd9) | AC;
  assign da_step1  = {1'b0, A} + (da_lo_adj ? 9'h006 : 9'h000);
  assign da_hi_adj = da_step1[8] | (da_step1[7:4] > 4'd9) | Cy;
  assign da_step2  = {1'b0, da_step1[7:0]} + (da_hi_adj ? 9'h060 : 9'h000);

  always_comb begin
    out_d.result    = A;
    out_d.carry     = Cy;
    out_d.aux_carry = AC;
    out_d.overflow  = 1'b0;
    case (ALUCode)
      ALU_INC, ALU_DEC: out_d.result = as_sum;
      ALU_ADD, ALU_ADDC, ALU_SUBB: begin
        out_d.result    = as_sum;
        out_d.carry     = as_c7;
        out_d.aux_carry = as_c3;
        out_d.overflow  = as_c7 ^ as_c6;
      end
      ALU_ORL: out_d.result = A | B;
      ALU_ANL: out_d.result = A & B;
      ALU_XRL: out_d.result = A ^ B;
      ALU_CPL: out_d.result = ~A;
      ALU_DA: begin
        out_d.result = da_step2[7:0];
        out_d.carry  = Cy | da_step1[8] | da_step2[8];
      end
      ALU_RR:  out_d.result = {A[0], A[7:1]};
      ALU_RRC: begin
        out_d.result = {Cy, A[7:1]};
        out_d.carry  = A[0];
      end
      ALU_RL:  out_d.result = {A[6:0], A[7]};
      ALU_RLC: begin
        out_d.result = {A[6:0], Cy};
        out_d.carry  = A[7];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign Result         = out_q.result;
  assign Carry          = out_q.carry;
  assign AssistantCarry = out_q.aux_carry;
  assign OVerflow       = out_q.overflow;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus random ops against an integer reference model.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [3:0] ALUCode;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cy;
  logic       AC;
  logic [7:0] Result;
  logic       Carry;
  logic       AssistantCarry;
  logic       OVerflow;

  int errors = 0;
  int checks = 0;

  alu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ALUCode        (ALUCode),
    .A              (A),
    .B              (B),
    .Cy             (Cy),
    .AC             (AC),
    .Result         (Result),
    .Carry          (Carry),
    .AssistantCarry (AssistantCarry),
    .OVerflow       (OVerflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_signed8(input logic [7:0] v);
    return v[7] ? int'(v) - 256 : int'(v);
  endfunction

  // Returns {result, carry, aux_carry, overflow} computed with plain integer arithmetic.
  function automatic logic [10:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                        input logic cy, input logic ac);
    int r;
    int s;
    int cin;
    logic [7:0] res;
    logic c;
    logic h;
    logic o;
    res = a;
    c = cy;
    h = ac;
    o = 1'b0;
    case (op)
      4'd0: begin r = int'(a) + 1; res = r[7:0]; end
      4'd1: begin r = int'(a) - 1; res = r[7:0]; end
      4'd2, 4'd3: begin
        cin = (op == 4'd3) ? int'(cy) : 0;
        r = int'(a) + int'(b) + cin;
        res = r[7:0];
        c = (r > 255);
        h = ((int'(a) % 16) + (int'(b) % 16) + cin) > 15;
        s = to_signed8(a) + to_signed8(b) + cin;
        o = (s > 127) || (s < -128);
      end
      4'd9: begin
        cin = int'(cy);
        r = int'(a) - int'(b) - cin;
        res = r[7:0];
        c = (r < 0);
        h = ((int'(a) % 16) - (int'(b) % 16) - cin) < 0;
        s = to_signed8(a) - to_signed8(b) - cin;
        o = (s > 127) || (s < -128);
      end
      4'd4: res = a | b;
      4'd5: res = a & b;
      4'd6: res = a ^ b;
      4'd7: res = ~a;
      4'd8: begin
        r = int'(a);
        if ((r % 16) > 9 || ac) r = r + 6;
        if ((r / 16) > 9 || cy) r = r + 96;
        res = r[7:0];
        c = cy || (r > 255);
      end
      4'd12: res = {a[0], a[7:1]};
      4'd13: begin res = {cy, a[7:1]}; c = a[0]; end
      4'd14: res = {a[6:0], a[7]};
      4'd15: begin res = {a[6:0], cy}; c = a[7]; end
      default: ;
    endcase
    return {res, c, h, o};
  endfunction

  task automatic step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic cy, input logic ac, input string tag);
    logic [10:0] exp;
    ALUCode = op; A = a; B = b; Cy = cy; AC = ac;
    exp = model(op, a, b, cy, ac);
    @(posedge clk);
    #1;
    checks++;
    assert ({Result, Carry, AssistantCarry, OVerflow} === exp)
    else begin
      errors++;
      $error("FAIL %s: got res=%h c=%b ac=%b ov=%b, expected res=%h c=%b ac=%b ov=%b", tag,
             Result, Carry, AssistantCarry, OVerflow, exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Directed step that also checks result/carry against hand-derived constants.
  task automatic dir(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic cy, input logic ac, input logic [7:0] exp_res, input logic exp_c,
                     input string tag);
    step(op, a, b, cy, ac, tag);
    checks++;
    assert ({Result, Carry} === {exp_res, exp_c})
    else begin
      errors++;
      $error("FAIL %s_const: got res=%h c=%b, expected res=%h c=%b", tag, Result, Carry, exp_res, exp_c);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ALUCode = 4'd0; A = 8'h00; B = 8'h00; Cy = 1'b0; AC = 1'b0;
    #2;
    checks++;
    assert ({Result, Carry, AssistantCarry, OVerflow} === 11'd0)
    else begin
      errors++;
      $error("FAIL reset: got %h, expected 000", {Result, Carry, AssistantCarry, OVerflow});
    end
    #10 rst_n = 1'b1;

    dir(4'b0010, 8'h01, 8'h09, 1'b1, 1'b0, 8'h0A, 1'b0, "add_01_09");
    dir(4'b0011, 8'h04, 8'h06, 1'b1, 1'b0, 8'h0B, 1'b0, "addc_04_06");
    dir(4'b1001, 8'h05, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0, "subb_05_05");
    dir(4'b1001, 8'h04, 8'h06, 1'b0, 1'b0, 8'hFE, 1'b1, "subb_04_06");
    dir(4'b0000, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, "inc_ff");
    dir(4'b0001, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, "dec_00");
    dir(4'b0111, 8'h55, 8'h12, 1'b0, 1'b0, 8'hAA, 1'b0, "cpl_55");
    dir(4'b0101, 8'h56, 8'h0F, 1'b0, 1'b0, 8'h06, 1'b0, "anl_56_0f");
    dir(4'b0100, 8'h65, 8'hF0, 1'b0, 1'b0, 8'hF5, 1'b0, "orl_65_f0");
    dir(4'b0110, 8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, "xrl_aa_55");
    dir(4'b1100, 8'hC3, 8'h00, 1'b0, 1'b0, 8'hE1, 1'b0, "rr_c3");
    dir(4'b1101, 8'hC3, 8'h00, 1'b0, 1'b0, 8'h61, 1'b1, "rrc_c3");
    dir(4'b1110, 8'h7E, 8'h00, 1'b0, 1'b0, 8'hFC, 1'b0, "rl_7e");
    dir(4'b1111, 8'h7E, 8'h00, 1'b1, 1'b0, 8'hFD, 1'b0, "rlc_7e");
    dir(4'b1000, 8'h0A, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0, "da_0a");
    dir(4'b1000, 8'h22, 8'h00, 1'b0, 1'b1, 8'h28, 1'b0, "da_22_ac");
    dir(4'b1000, 8'h22, 8'h00, 1'b1, 1'b0, 8'h82, 1'b1, "da_22_cy");
    dir(4'b1000, 8'hA2, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, "da_a2");
    dir(4'b0010, 8'h79, 8'h07, 1'b1, 1'b0, 8'h80, 1'b0, "add_79_07");
    dir(4'b0010, 8'h79, 8'h77, 1'b1, 1'b0, 8'hF0, 1'b0, "add_79_77");
    dir(4'b0010, 8'h87, 8'h07, 1'b1, 1'b0, 8'h8E, 1'b0, "add_87_07");
    dir(4'b1001, 8'h79, 8'h7A, 1'b1, 1'b0, 8'hFE, 1'b1, "subb_79_7a");
    dir(4'b1001, 8'h79, 8'h87, 1'b1, 1'b0, 8'hF1, 1'b1, "subb_79_87");
    dir(4'b1001, 8'h87, 8'h0E, 1'b1, 1'b0, 8'h78, 1'b0, "subb_87_0e");
    dir(4'b1010, 8'h3C, 8'h99, 1'b1, 1'b1, 8'h3C, 1'b1, "unused_1010");
    dir(4'b1011, 8'hC5, 8'h11, 1'b0, 1'b1, 8'hC5, 1'b0, "unused_1011");

    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), $sformatf("rand_%0d", i));
    end

    // Asynchronous reset between edges, then capture on the first edge after release.
    step(4'b0000, 8'h7F, 8'h00, 1'b1, 1'b1, "pre_reset");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    assert ({Result, Carry, AssistantCarry, OVerflow} === 11'd0)
    else begin
      errors++;
      $error("FAIL async_reset: got %h, expected 000", {Result, Carry, AssistantCarry, OVerflow});
    end
    #1 rst_n = 1'b1;
    step(4'b0010, 8'h79, 8'h07, 1'b0, 1'b0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
